bcd_to_binary_seq: RTL

//  Sequential BCD-to-binary converter using reverse double dabble: shift right one bit
//  per cycle, then subtract 3 from every BCD digit >= 8. It is the return path for the

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_to_binary_seq_if.sv | 26 ++
 rtl/bcd_digit_sub3.sv | 7 +
 rtl/bcd_to_binary_seq.sv | 117 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary<->BCD converter pair.
// Holds the FSM state type, the digit width and a digit validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/done handshake bundle for the BCD-to-binary converter.
// The master issues start and bcd_in, and the slave returns the result and status.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  // start is taken only on an edge where ready=1. done pulses for one cycle,
  // and binary_out/err are valid from that pulse until the next accepted start.
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      binary_out;
  bcd_pkg::b2b_state_t   state;

  modport master (
    output start, bcd_in,
    input  ready, done, err, binary_out, state
  );

  modport slave (
    input  start, bcd_in,
    output ready, done, err, binary_out, state
  );
endinterface

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: subtract 3 from a digit that is 8 or more.
module bcd_digit_sub3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);
  assign corrected = (digit >= 4'd8) ? (digit - 4'd3) : digit;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter that uses reverse double dabble.
// Each cycle it shifts right by one bit and corrects every BCD digit that is 8 or more.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  bcd_to_binary_seq_if.slave  bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int W_W   = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam longint MAX_DEC   = (64'd10 ** DIGITS) - 64'd1;
  localparam longint BIN_RANGE = 64'd1 << BIN_W;

  if (BIN_RANGE <= MAX_DEC) begin : g_bin_w_check
    $error("bcd_to_binary_seq: BIN_W too narrow for DIGITS");
  end

  b2b_state_t         state;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   count;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic [BIN_W-1:0]   result_q;

  logic [W_W-1:0]     w_sh;
  logic [BCD_W-1:0]   bcd_sh;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   bcd_corr;
  logic               all_valid;

  assign w_sh   = {bcd_q, bin_q} >> 1;
  assign bcd_sh = w_sh[W_W-1:BIN_W];
  assign bin_sh = w_sh[BIN_W-1:0];

  // Correction looks only at the post-shift digits and never carries between digits.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit     (bcd_sh[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .corrected (bcd_corr[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(bus.bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W])) all_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      count    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            if (!all_valid) begin
              // An invalid operand skips the shift phase and reports at once.
              state    <= DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end else begin
              bcd_q   <= bus.bcd_in;
              bin_q   <= '0;
              count   <= '0;
              err_q   <= 1'b0;
              ready_q <= 1'b0;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_corr;
          bin_q <= bin_sh;
          count <= count + 1'b1;
          if (count == CNT_W'(BIN_W - 1)) begin
            state    <= DONE;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            result_q <= bin_sh;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.binary_out = result_q;

endmodule
